qed_instruction_scheduler: RTL and testbench
============================================

// Module: qed_instruction_scheduler
// PURPOSE
//  Sequences QED execution between the fetch stage and the QED instruction-modify path.
//  - Passes original instructions through and queues each one.
//  - On request, or when the queue is full, replays the queued instructions as duplicates.
//  - Drives qed_dup, which selects the modified (duplicate) encoding downstream.
//  - Tracks issued original/duplicate counts and flags the QED-consistent point for the formal checker.
// PARAMETERS
//  DEPTH  8   queue depth in instructions; power of 2, >=2
//  CNT_W  6   width of the original/duplicate issue counters
// PORTS
//  clk                    in   1      clock
//  rst                    in   1      synchronous reset, active-high
//  stall                  in   1      pipeline stall: hold all state and outputs
//  exec_dup               in   1      free input (formal tool): request duplicate phase
//  ifu_qed_instruction    in   32     instruction from fetch
//  ifu_qed_valid          in   1      ifu_qed_instruction is valid this cycle
//  qic_qimux_instruction  out  32     instruction to the modify path / decoder
//  qed_dup                out  1      1 = issue qic_qimux_instruction in modified (duplicate) form
//  qed_ifu_ready          out  1      scheduler accepts a fetch instruction this cycle
//  qed_num_orig           out  CNT_W  originals issued since reset
//  qed_num_dup            out  CNT_W  duplicates issued since reset
//  qed_ready              out  1      registered: counts equal, nonzero, queue empty
// BEHAVIOUR
//  Interface
//  - Clock is clk. Reset is rst: synchronous, active-high.
//  - Reset values: state=ORIG, queue empty, counters 0.
//  - Reset outputs: qic_qimux_instruction=NOP (32'h00000013), qed_dup=0, qed_ready=0.
//  - Fetch acceptance: qed_ifu_ready = (state==ORIG) & !full & !stall (combinational).
//  - A fetch is accepted when ifu_qed_valid & qed_ifu_ready.
//  - Registered outputs, 1-cycle latency: qic_qimux_instruction, qed_dup, qed_ready.
//  State ORIG
//  - Accepted fetch: next output = ifu_qed_instruction, qed_dup=0.
//  - Accepted fetch also pushes the instruction into the queue and increments num_orig.
//  - No accepted fetch: next output = NOP, qed_dup=0; no push, no count.
//  - To DUP when (exec_dup & !empty) | full.
//  - The transition check uses occupancy after this cycle's push.
//  - exec_dup in the same cycle as a fetch: the fetch is taken first, then the state moves to DUP.
//  State DUP
//  - Each non-stall cycle pops the queue head.
//  - Next output = popped instruction, qed_dup=1; num_dup increments.
//  - No fetch is accepted in DUP.
//  - To ORIG on the cycle the last entry is popped.
//  - A DUP phase always drains the queue completely; exec_dup is ignored in DUP.
//  stall
//  - Freezes state, queue, counters and all registered outputs.
//  - Has priority over every transition.
//  Counters
//  - Wrap modulo 2^CNT_W.
//  - qed_ready = (num_orig==num_dup) & (num_orig!=0) & empty, registered.
//  Invariants (checked as assertions)
//  - num_orig - num_dup (mod 2^CNT_W) == occupancy.
//  - occupancy <= DEPTH.
//  - No push when full; no pop when empty.
//  - Duplicates are issued in the same order as their originals.
//  Reset mid-phase
//  - rst in DUP discards queued entries; the next cycle is ORIG with NOP output.
// STRUCTURE
//  - Shared package qed_pkg:
//    - QED_NOP = 32'h00000013
//    - typedef enum {QED_ORIG, QED_DUP} qed_state_t
//    - the instruction-word typedef
//  - One sub-module, qed_inst_fifo (DEPTH x 32, push/pop, full/empty, count).
//    - A simultaneous push and pop never occurs by construction; assert this.
//  - FSM, counters and output registers live in the top module.
//  - modify_instruction stays downstream, steered by qed_dup.
// TESTING
//  1. Reset, then 3 valid fetches A,B,C with exec_dup=0.
//     -> outputs A,B,C, qed_dup=0; num_orig=3; qed_ready=0.
//  2. Then exec_dup=1 for 1 cycle.
//     -> 3 cycles of outputs A,B,C with qed_dup=1, qed_ifu_ready=0.
//     -> num_dup=3; qed_ready=1 the cycle after C; state back to ORIG.
//  3. 8 consecutive fetches with exec_dup=0 (DEPTH=8).
//     -> qed_ifu_ready drops after the 8th; forced DUP replays all 8.
//  4. stall=1 for 2 cycles mid-DUP (after 1 of 3 pops).
//     -> outputs, counters and occupancy frozen; remaining 2 duplicates follow after stall clears.
//  5. rst=1 while in DUP with 2 entries left.
//     -> next cycle: NOP, qed_dup=0, counts 0, queue empty.
//  6. exec_dup=1 with the queue empty in ORIG.
//     -> stay in ORIG, NOP output, no count change.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared types and constants for the QED instruction scheduler and its queue.
package qed_pkg;

   localparam logic [31:0] QED_NOP = 32'h00000013;

   typedef logic [31:0] qed_instr_t;

   typedef enum logic [0:0] {
      QED_ORIG = 1'b0,
      QED_DUP  = 1'b1
   } qed_state_t;

endpackage

// File: rtl/qed_inst_fifo.sv
// Instruction queue holding issued originals until they are replayed as duplicates.
module qed_inst_fifo
   import qed_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  qed_instr_t    wdata,
   output qed_instr_t    rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   qed_instr_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && pop));
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/qed_instruction_scheduler.sv
// Issues fetched instructions as originals, queues them, then replays them as QED duplicates.
module qed_instruction_scheduler
   import qed_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             exec_dup,
   input  logic [31:0]      ifu_qed_instruction,
   input  logic             ifu_qed_valid,
   output logic [31:0]      qic_qimux_instruction,
   output logic             qed_dup,
   output logic             qed_ifu_ready,
   output logic [CNT_W-1:0] qed_num_orig,
   output logic [CNT_W-1:0] qed_num_dup,
   output logic             qed_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   qed_state_t    state;
   qed_instr_t    head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic          accept;
   logic          pop;
   logic          go_dup;

   assign qed_ifu_ready = (state == QED_ORIG) && !full && !stall;
   assign accept        = ifu_qed_valid && qed_ifu_ready;
   assign pop           = (state == QED_DUP) && !stall && !empty;

   // The decision to enter DUP looks at occupancy including this cycle's push.
   assign count_after = count + CW'(accept);
   assign go_dup      = (exec_dup && (count_after != '0)) || (count_after == CW'(DEPTH));

   qed_inst_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .wdata (ifu_qed_instruction),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= QED_ORIG;
         qic_qimux_instruction <= QED_NOP;
         qed_dup               <= 1'b0;
         qed_ready             <= 1'b0;
         qed_num_orig          <= '0;
         qed_num_dup           <= '0;
      end else if (!stall) begin
         qed_ready <= (qed_num_orig == qed_num_dup) && (qed_num_orig != '0) && empty;
         case (state)
            QED_ORIG: begin
               qic_qimux_instruction <= accept ? ifu_qed_instruction : QED_NOP;
               qed_dup               <= 1'b0;
               if (accept) begin
                  qed_num_orig <= qed_num_orig + CNT_W'(1);
               end
               if (go_dup) begin
                  state <= QED_DUP;
               end
            end
            QED_DUP: begin
               // A DUP phase only ends once the queue has been fully drained.
               if (!empty) begin
                  qic_qimux_instruction <= head;
                  qed_dup               <= 1'b1;
                  qed_num_dup           <= qed_num_dup + CNT_W'(1);
                  if (count == CW'(1)) begin
                     state <= QED_ORIG;
                  end
               end else begin
                  qic_qimux_instruction <= QED_NOP;
                  qed_dup               <= 1'b0;
                  state                 <= QED_ORIG;
               end
            end
            default: begin
               state <= QED_ORIG;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((qed_num_orig - qed_num_dup) == CNT_W'(count));
         assert (count <= CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_qed_instruction_scheduler.sv
// Directed bench with a scoreboard of expected registered outputs for the QED scheduler.
module tb_qed_instruction_scheduler;
   import qed_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 6;

   typedef struct packed {
      logic [31:0]      instr;
      logic             dup;
      logic             ready;
      logic [CNT_W-1:0] norig;
      logic [CNT_W-1:0] ndup;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             exec_dup;
   logic [31:0]      ifu_qed_instruction;
   logic             ifu_qed_valid;
   logic [31:0]      qic_qimux_instruction;
   logic             qed_dup;
   logic             qed_ifu_ready;
   logic [CNT_W-1:0] qed_num_orig;
   logic [CNT_W-1:0] qed_num_dup;
   logic             qed_ready;

   int checkCount = 0;
   int passCount  = 0;

   exp_t             sb[$];
   logic [31:0]      mQ[$];
   logic             mInDup;
   logic [CNT_W-1:0] mOrig;
   logic [CNT_W-1:0] mDup;
   exp_t             mCur;

   qed_instruction_scheduler #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .stall                 (stall),
      .exec_dup              (exec_dup),
      .ifu_qed_instruction   (ifu_qed_instruction),
      .ifu_qed_valid         (ifu_qed_valid),
      .qic_qimux_instruction (qic_qimux_instruction),
      .qed_dup               (qed_dup),
      .qed_ifu_ready         (qed_ifu_ready),
      .qed_num_orig          (qed_num_orig),
      .qed_num_dup           (qed_num_dup),
      .qed_ready             (qed_ready)
   );

   always #5 clk = ~clk;

   task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checkCount++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = sb.pop_front();
         checkField({tag, ".instr"}, qic_qimux_instruction, e.instr);
         checkField({tag, ".dup"},   32'(qed_dup),          32'(e.dup));
         checkField({tag, ".ready"}, 32'(qed_ready),        32'(e.ready));
         checkField({tag, ".norig"}, 32'(qed_num_orig),     32'(e.norig));
         checkField({tag, ".ndup"},  32'(qed_num_dup),      32'(e.ndup));
      end
   endtask

   task automatic doReset();
      rst = 1'b1; stall = 1'b0; exec_dup = 1'b0;
      ifu_qed_valid = 1'b0; ifu_qed_instruction = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mQ.delete();
      sb.delete();
      mInDup = 1'b0;
      mOrig  = '0;
      mDup   = '0;
      mCur   = '{instr: QED_NOP, dup: 1'b0, ready: 1'b0, norig: '0, ndup: '0};
      sb.push_back(mCur);
      checkOutput("reset");
   endtask

   // Drives one cycle of inputs, predicts the next registered outputs, then checks them.
   task automatic applyStimulus(input string tag, input logic valid, input logic [31:0] instr,
                                input logic exec, input logic stl);
      logic expIfuReady;
      logic acc;
      exp_t nxt;
      ifu_qed_valid = valid; ifu_qed_instruction = instr;
      exec_dup = exec; stall = stl;
      #1;
      expIfuReady = !mInDup && (mQ.size() < DEPTH) && !stl;
      checkField({tag, ".ifu_ready"}, 32'(qed_ifu_ready), 32'(expIfuReady));
      if (!stl) begin
         nxt.ready = (mOrig == mDup) && (mOrig != '0) && (mQ.size() == 0);
         if (!mInDup) begin
            acc = valid && expIfuReady;
            nxt.instr = acc ? instr : QED_NOP;
            nxt.dup = 1'b0;
            if (acc) begin
               mQ.push_back(instr);
               mOrig = mOrig + 1'b1;
            end
            if ((exec && mQ.size() != 0) || mQ.size() == DEPTH) mInDup = 1'b1;
         end else begin
            nxt.instr = mQ.pop_front();
            nxt.dup = 1'b1;
            mDup = mDup + 1'b1;
            if (mQ.size() == 0) mInDup = 1'b0;
         end
         nxt.norig = mOrig;
         nxt.ndup  = mDup;
         mCur = nxt;
      end
      sb.push_back(mCur);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      $display("[TB] start");
      doReset();

      applyStimulus("t1_a", 1'b1, 32'hA000_000A, 1'b0, 1'b0);
      applyStimulus("t1_b", 1'b1, 32'hB000_000B, 1'b0, 1'b0);
      applyStimulus("t1_c", 1'b1, 32'hC000_000C, 1'b0, 1'b0);
      checkField("t1_num_orig", 32'(qed_num_orig), 32'd3);
      checkField("t1_qed_ready", 32'(qed_ready), 32'd0);

      applyStimulus("t2_exec", 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus("t2_dup", 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
      checkField("t2_last_dup", qic_qimux_instruction, 32'hC000_000C);
      applyStimulus("t2_idle", 1'b0, 32'h0, 1'b0, 1'b0);
      checkField("t2_num_dup", 32'(qed_num_dup), 32'd3);
      checkField("t2_qed_ready", 32'(qed_ready), 32'd1);

      for (int i = 0; i < DEPTH; i++) applyStimulus("t3_fill", 1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("t3_drain", 1'b1, 32'h3F00_0000 + 32'(i), 1'b0, 1'b0);
      checkField("t3_num_dup", 32'(qed_num_dup), 32'd11);
      applyStimulus("t3_idle", 1'b0, 32'h0, 1'b0, 1'b0);

      applyStimulus("t4_x", 1'b1, 32'h4000_0001, 1'b0, 1'b0);
      applyStimulus("t4_y", 1'b1, 32'h4000_0002, 1'b0, 1'b0);
      applyStimulus("t4_z", 1'b1, 32'h4000_0003, 1'b1, 1'b0);
      applyStimulus("t4_pop1", 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus("t4_stall", 1'b1, 32'h4000_00FF, 1'b1, 1'b1);
      applyStimulus("t4_stall", 1'b1, 32'h4000_00FF, 1'b0, 1'b1);
      checkField("t4_frozen", qic_qimux_instruction, 32'h4000_0001);
      applyStimulus("t4_pop2", 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus("t4_pop3", 1'b0, 32'h0, 1'b0, 1'b0);
      checkField("t4_last", qic_qimux_instruction, 32'h4000_0003);

      applyStimulus("t5_p", 1'b1, 32'h5000_0001, 1'b0, 1'b0);
      applyStimulus("t5_q", 1'b1, 32'h5000_0002, 1'b0, 1'b0);
      applyStimulus("t5_r", 1'b1, 32'h5000_0003, 1'b1, 1'b0);
      applyStimulus("t5_pop1", 1'b0, 32'h0, 1'b0, 1'b0);
      doReset();
      applyStimulus("t5_after", 1'b0, 32'h0, 1'b0, 1'b0);

      applyStimulus("t6_exec_empty", 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus("t6_exec_empty", 1'b0, 32'h0, 1'b1, 1'b0);
      checkField("t6_num_orig", 32'(qed_num_orig), 32'd0);
      applyStimulus("t6_fetch", 1'b1, 32'h6000_0001, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
